// File: rtl/vga_sync_gen_if.sv
// Bus between the VGA raster timing generator and its consumers.
// The master side is the generator: it takes the pixel tick and drives the
// counts, syncs, video_on and strobes. The slave side is a renderer.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if #(
    parameter int CNT_W = 10
);
    logic             pix_tick;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             line_end;
    logic             frame_end;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    modport master (
`ifdef VGA_FRAME_CNT_EN
        output frame_cnt,
`endif
        input  pix_tick,
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output video_on,
        output line_end,
        output frame_end
    );

    modport slave (
`ifdef VGA_FRAME_CNT_EN
        input  frame_cnt,
`endif
        output pix_tick,
        input  hcount,
        input  vcount,
        input  hsync,
        input  vsync,
        input  video_on,
        input  line_end,
        input  frame_end
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator.
// Advances a column/line counter pair once per pix_tick. hsync, vsync and
// video_on are decoded from the next-state counts and registered, so they
// always describe the hcount/vcount visible in the same cycle. line_end and
// frame_end are combinational strobes that fire on the tick that leaves the
// last pixel of a line / frame.
// Optional feature: define VGA_FRAME_CNT_EN to add a 16-bit wrapping frame
// counter (frame_cnt) that steps on every frame_end.
// Handshake: pix_tick is a one-clk enable with no back-pressure; the
// generator consumes every tick it sees, and nothing advances without one.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CNT_W     = 10
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             line_end;
    logic             frame_end;

    // Next-state counts and the sync/blanking decode of those counts
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (bus.pix_tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end
        hsync_d    = ((hcount_d >= HS_START) && (hcount_d < HS_STOP)) ? HS_POL : ~HS_POL;
        vsync_d    = ((vcount_d >= VS_START) && (vcount_d < VS_STOP)) ? VS_POL : ~VS_POL;
        video_on_d = (hcount_d < H_VIS) && (vcount_d < V_VIS);
    end

    // Counter and decoded-output registers; reset returns to pixel (0,0)
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            hsync_q    <= ~HS_POL;
            vsync_q    <= ~VS_POL;
            video_on_q <= 1'b1;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    // Strobes mark the tick that leaves the last pixel; suppressed in reset
    always_comb begin
        line_end  = ~rst & bus.pix_tick & (hcount_q == H_LAST);
        frame_end = line_end & (vcount_q == V_LAST);
    end

    assign bus.hcount    = hcount_q;
    assign bus.vcount    = vcount_q;
    assign bus.hsync     = hsync_q;
    assign bus.vsync     = vsync_q;
    assign bus.video_on  = video_on_q;
    assign bus.line_end  = line_end;
    assign bus.frame_end = frame_end;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Frame counter for animation phase; wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a small raster (8 x 6). The reference model
// tracks a single linear pixel position since reset and derives column,
// line, syncs, blanking and strobes from it arithmetically.
module tb_vga_sync_gen;
  localparam int H_VIS = 4, H_FP = 1, H_SY = 2, H_BP = 1;
  localparam int V_VIS = 3, V_FP = 1, V_SY = 1, V_BP = 1;
  localparam int HT = H_VIS + H_FP + H_SY + H_BP;
  localparam int VT = V_VIS + V_FP + V_SY + V_BP;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_gen_if #(.CNT_W(CW)) bus ();

  vga_sync_gen #(
    .H_VISIBLE(H_VIS), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_VISIBLE(V_VIS), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int mpos = 0;          // pixel position within frame since reset
  int mfc = 0;           // frames completed (mod 2^16)
  int pre_h, pre_v;      // model position before the last edge
  bit exp_le, exp_fe;    // expected strobes for the last cycle
  logic obs_le, obs_fe;  // observed strobes for the last cycle

  function automatic int m_h();
    return mpos % HT;
  endfunction
  function automatic int m_v();
    return mpos / HT;
  endfunction
  function automatic logic m_hs();
    return (m_h() >= H_VIS + H_FP && m_h() < H_VIS + H_FP + H_SY) ? 1'b0 : 1'b1;
  endfunction
  function automatic logic m_vs();
    return (m_v() >= V_VIS + V_FP && m_v() < V_VIS + V_FP + V_SY) ? 1'b0 : 1'b1;
  endfunction
  function automatic logic m_von();
    return (m_h() < H_VIS && m_v() < V_VIS) ? 1'b1 : 1'b0;
  endfunction

  // ---------------- driver ----------------
  // One clock: drive at negedge, capture strobes, advance model at posedge.
  task automatic cycle(input bit r, input bit t);
    @(negedge clk);
    rst = r;
    bus.pix_tick = t;
    #1;
    obs_le = bus.line_end;
    obs_fe = bus.frame_end;
    pre_h = m_h();
    pre_v = m_v();
    exp_le = !r && t && (pre_h == HT - 1);
    exp_fe = exp_le && (pre_v == VT - 1);
    @(posedge clk);
    if (r) begin
      mpos = 0;
      mfc = 0;
    end else if (t) begin
      if (exp_fe) mfc = (mfc + 1) % 65536;
      mpos = (mpos + 1) % (HT * VT);
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cycle(1, 0);
    cycle(1, 0);
    checks++;
    if (bus.hcount !== 4'd0 || bus.vcount !== 4'd0) begin
      failures++;
      $display("FAIL reset_counts: got (%0d,%0d) want (0,0)", bus.hcount, bus.vcount);
    end
    checks++;
    if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1 || bus.video_on !== 1'b1) begin
      failures++;
      $display("FAIL reset_outs: hs=%b vs=%b von=%b want 1 1 1", bus.hsync, bus.vsync, bus.video_on);
    end
    checks++;
    if (obs_le !== 1'b0 || obs_fe !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: le=%b fe=%b want 0 0", obs_le, obs_fe);
    end
  endtask

  task automatic test_full_rate();
    int hs_low_mask = 0;
    int von_low_mask = 0;
    int le_at = -1;
    cycle(0, 0);  // release reset
    for (int i = 0; i < HT; i++) begin
      if (bus.hsync === 1'b0) hs_low_mask |= (1 << bus.hcount);
      if (bus.video_on === 1'b0) von_low_mask |= (1 << bus.hcount);
      cycle(0, 1);
      if (obs_le === 1'b1) le_at = pre_h;
      checks++;
      if (bus.hcount !== CW'(m_h()) || bus.vcount !== CW'(m_v())) begin
        failures++;
        $display("FAIL full_rate_count: got (%0d,%0d) want (%0d,%0d)", bus.hcount, bus.vcount, m_h(), m_v());
      end
    end
    checks++;
    if (hs_low_mask !== 32'h60) begin
      failures++;
      $display("FAIL full_rate_hsync: low-at mask got %h want 60", hs_low_mask);
    end
    checks++;
    if (von_low_mask !== 32'hF0) begin
      failures++;
      $display("FAIL full_rate_video_on: low-at mask got %h want f0", von_low_mask);
    end
    checks++;
    if (le_at !== 7) begin
      failures++;
      $display("FAIL full_rate_line_end: fired at hcount %0d want 7", le_at);
    end
    checks++;
    if (bus.hcount !== 4'd0 || bus.vcount !== 4'd1) begin
      failures++;
      $display("FAIL full_rate_wrap: got (%0d,%0d) want (0,1)", bus.hcount, bus.vcount);
    end
  endtask

  task automatic test_div4();
    int le_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      cycle(0, (c % 4) == 3);
      if (obs_le === 1'b1) le_cnt++;
      checks++;
      if (bus.hcount !== CW'(m_h()) || bus.vcount !== CW'(m_v()) ||
          bus.hsync !== m_hs() || bus.video_on !== m_von() || obs_le !== exp_le) begin
        failures++;
        $display("FAIL div4_step%0d: got (%0d,%0d) hs=%b von=%b le=%b want (%0d,%0d) hs=%b von=%b le=%b",
                 c, bus.hcount, bus.vcount, bus.hsync, bus.video_on, obs_le,
                 m_h(), m_v(), m_hs(), m_von(), exp_le);
      end
    end
    checks++;
    if (le_cnt !== 1) begin
      failures++;
      $display("FAIL div4_line_end_count: got %0d want 1", le_cnt);
    end
  endtask

  task automatic test_frame();
    int fe_cnt = 0;
    int fe_h = -1, fe_v = -1;
    bit vs_bad = 0;
    cycle(1, 0);
    for (int i = 0; i < HT * VT; i++) begin
      cycle(0, 1);
      if (obs_fe === 1'b1) begin
        fe_cnt++;
        fe_h = pre_h;
        fe_v = pre_v;
      end
      if (bus.vsync !== ((bus.vcount == 4'd4) ? 1'b0 : 1'b1)) vs_bad = 1;
      checks++;
      if (bus.vsync !== m_vs() || bus.hsync !== m_hs() || obs_fe !== exp_fe) begin
        failures++;
        $display("FAIL frame_step%0d: vs=%b hs=%b fe=%b want vs=%b hs=%b fe=%b",
                 i, bus.vsync, bus.hsync, obs_fe, m_vs(), m_hs(), exp_fe);
      end
    end
    checks++;
    if (vs_bad) begin
      failures++;
      $display("FAIL frame_vsync_line4: vsync not low exactly on line 4");
    end
    checks++;
    if (fe_cnt !== 1 || fe_h !== 7 || fe_v !== 5) begin
      failures++;
      $display("FAIL frame_end: count=%0d at (%0d,%0d) want 1 at (7,5)", fe_cnt, fe_h, fe_v);
    end
    checks++;
    if (bus.hcount !== 4'd0 || bus.vcount !== 4'd0) begin
      failures++;
      $display("FAIL frame_wrap: got (%0d,%0d) want (0,0)", bus.hcount, bus.vcount);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0);
    for (int i = 0; i < 2 * HT + 3; i++) cycle(0, 1);
    checks++;
    if (bus.hcount !== 4'd3 || bus.vcount !== 4'd2) begin
      failures++;
      $display("FAIL reset_mid_pos: got (%0d,%0d) want (3,2)", bus.hcount, bus.vcount);
    end
    cycle(1, 1);
    checks++;
    if (bus.hcount !== 4'd0 || bus.vcount !== 4'd0 || bus.hsync !== 1'b1 ||
        bus.vsync !== 1'b1 || obs_le !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got (%0d,%0d) hs=%b vs=%b le=%b want (0,0) 1 1 0",
               bus.hcount, bus.vcount, bus.hsync, bus.vsync, obs_le);
    end
    // Reset on the last pixel of the frame with a tick: strobes stay low.
    for (int i = 0; i < HT * VT - 1; i++) cycle(0, 1);
    cycle(1, 1);
    checks++;
    if (obs_le !== 1'b0 || obs_fe !== 1'b0 || bus.hcount !== 4'd0 || bus.vcount !== 4'd0) begin
      failures++;
      $display("FAIL reset_last_pixel: le=%b fe=%b pos (%0d,%0d) want 0 0 (0,0)",
               obs_le, obs_fe, bus.hcount, bus.vcount);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0));
      checks++;
      if (bus.hcount !== CW'(m_h()) || bus.vcount !== CW'(m_v()) || bus.hsync !== m_hs() ||
          bus.vsync !== m_vs() || bus.video_on !== m_von() || obs_le !== exp_le || obs_fe !== exp_fe) begin
        failures++;
        $display("FAIL random_step%0d: got (%0d,%0d) %b%b%b le=%b fe=%b want (%0d,%0d) %b%b%b le=%b fe=%b",
                 i, bus.hcount, bus.vcount, bus.hsync, bus.vsync, bus.video_on, obs_le, obs_fe,
                 m_h(), m_v(), m_hs(), m_vs(), m_von(), exp_le, exp_fe);
      end
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    cycle(1, 0);
    checks++;
    if (bus.frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL frame_cnt_reset: got %0d want 0", bus.frame_cnt);
    end
    for (int i = 0; i < 3 * HT * VT; i++) cycle(0, 1);
    checks++;
    if (bus.frame_cnt !== 16'd3 || bus.frame_cnt !== 16'(mfc)) begin
      failures++;
      $display("FAIL frame_cnt_3: got %0d want 3", bus.frame_cnt);
    end
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // ---------------- sequence + report ----------------
  initial begin
    bus.pix_tick = 1'b0;
    test_reset();
    test_full_rate();
    test_div4();
    test_frame();
    test_reset_mid();
    test_random();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
